// File: rtl/div_unit_pkg.sv
// Shared types and RV32M divide opcode encodings for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it does not go negative.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_in < divisor, so shifted < 2*divisor and the top bit of diff is a clean borrow flag
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (one quotient bit per cycle).
// Optional DIV_RESULT_CACHE_EN keeps the last quotient/remainder pair for one-cycle repeats.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  div_state_t      state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] dvd_reg, dvs_reg, rem_reg, result_reg;
  logic            neg_q_reg, neg_r_reg, rem_sel_reg;

  logic            accept, in_signed, in_rem, dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic            div_zero, overflow, special, fast, last;
  logic [XLEN-1:0] spec_quot, spec_rem, fast_quot, fast_rem;
  logic [XLEN-1:0] rem_out, q_final, quot_fix, rem_fix;
  logic            q_bit;

  assign accept    = start & ~flush & (state_reg != ST_CALC);
  assign in_signed = ~((op == DIV_OP_DIVU) | (op == DIV_OP_REMU));
  assign in_rem    = (op == DIV_OP_REM) | (op == DIV_OP_REMU);
  assign dvd_neg   = in_signed & dividend[XLEN-1];
  assign dvs_neg   = in_signed & divisor[XLEN-1];
  assign dvd_abs   = dvd_neg ? -dividend : dividend;
  assign dvs_abs   = dvs_neg ? -divisor : divisor;

  // Architecturally defined corner cases bypass the iteration entirely
  assign div_zero  = (divisor == '0);
  assign overflow  = in_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);
  assign special   = div_zero | overflow;
  assign spec_quot = div_zero ? '1 : dividend;
  assign spec_rem  = div_zero ? dividend : '0;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_reg),
    .dvd_bit (dvd_reg[XLEN-1]),
    .divisor (dvs_reg),
    .rem_out (rem_out),
    .q_bit   (q_bit)
  );

  // Dividend register doubles as the quotient shift register
  assign q_final  = {dvd_reg[XLEN-2:0], q_bit};
  assign quot_fix = neg_q_reg ? -q_final : q_final;
  assign rem_fix  = neg_r_reg ? -rem_out : rem_out;
  assign last     = (state_reg == ST_CALC) && (count_reg == '0) && !flush;

`ifdef DIV_RESULT_CACHE_EN
  logic [XLEN-1:0] req_dvd_reg, req_dvs_reg;
  logic            req_signed_reg;
  logic [XLEN-1:0] c_dvd_reg, c_dvs_reg, c_quot_reg, c_rem_reg;
  logic            c_signed_reg, c_valid_reg, hit;

  assign hit       = c_valid_reg & (c_dvd_reg == dividend) & (c_dvs_reg == divisor)
                   & (c_signed_reg == in_signed);
  assign fast      = special | hit;
  assign fast_quot = special ? spec_quot : c_quot_reg;
  assign fast_rem  = special ? spec_rem : c_rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_dvd_reg    <= '0;
      req_dvs_reg    <= '0;
      req_signed_reg <= 1'b0;
      c_dvd_reg      <= '0;
      c_dvs_reg      <= '0;
      c_quot_reg     <= '0;
      c_rem_reg      <= '0;
      c_signed_reg   <= 1'b0;
      c_valid_reg    <= 1'b0;
    end else if (accept) begin
      req_dvd_reg    <= dividend;
      req_dvs_reg    <= divisor;
      req_signed_reg <= in_signed;
      if (fast) begin
        c_dvd_reg    <= dividend;
        c_dvs_reg    <= divisor;
        c_signed_reg <= in_signed;
        c_quot_reg   <= fast_quot;
        c_rem_reg    <= fast_rem;
        c_valid_reg  <= 1'b1;
      end
    end else if (last) begin
      c_dvd_reg    <= req_dvd_reg;
      c_dvs_reg    <= req_dvs_reg;
      c_signed_reg <= req_signed_reg;
      c_quot_reg   <= quot_fix;
      c_rem_reg    <= rem_fix;
      c_valid_reg  <= 1'b1;
    end
  end
`else
  assign fast      = special;
  assign fast_quot = spec_quot;
  assign fast_rem  = spec_rem;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: state_next = accept ? (fast ? ST_DONE : ST_CALC) : ST_IDLE;
      ST_CALC:          if (count_reg == '0) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      result_reg  <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        count_reg   <= CW'(XLEN-1);
        dvd_reg     <= dvd_abs;
        dvs_reg     <= dvs_abs;
        rem_reg     <= '0;
        neg_q_reg   <= dvd_neg ^ dvs_neg;
        neg_r_reg   <= dvd_neg;
        rem_sel_reg <= in_rem;
        if (fast) result_reg <= in_rem ? fast_rem : fast_quot;
      end else if (state_reg == ST_CALC) begin
        count_reg <= count_reg - 1'b1;
        dvd_reg   <= q_final;
        rem_reg   <= rem_out;
        if (last) result_reg <= rem_sel_reg ? rem_fix : quot_fix;
      end
    end
  end

  assign busy   = (state_reg == ST_CALC);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, sign handling, special cases, flush/reset abort,
// back-to-back starts and (with DIV_RESULT_CACHE_EN) result-cache hits.
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive cycle 0 from the current negedge; return at the negedge of cycle 1 with operands scrambled
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; op = ~o; dividend = 32'hDEAD_BEEF; divisor = 32'h1234_5678;
  endtask

  // Called at the negedge of cycle cyc0; returns at the negedge of the done cycle
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat,
                           input int cyc0);
    int cyc = cyc0;
    int busy_cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busycyc"}, busy_cyc, (exp_lat > 1) ? exp_lat - cyc0 : 0);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_res"}, result, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk);
    launch(o, a, b);
    wait_done(tag, exp_res, exp_lat, 1);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, HIT_LAT);
    run_op("div_m7_2",   DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, HIT_LAT);
    run_op("div_7_m2",   DIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("divu_5_0",   DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0",    DIV_OP_REM,  32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("div_100_7",  DIV_OP_DIV,  32'd100, 32'd7, 32'd14, 33);
    run_op("rem_100_7",  DIV_OP_REM,  32'd100, 32'd7, 32'd2, HIT_LAT);
    run_op("remu_miss",  DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    // Flush mid-op at cycle 10, restart at cycle 12
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd1000, 32'd7);
    check("flush_busy_c1", {31'd0, busy}, 32'd1);
    dones = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) dones++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_c11", {31'd0, busy}, 32'd0);
    check("flush_done_c11", {31'd0, done}, 32'd0);
    check("flush_no_done", dones, 0);
    check("flush_res_hold", result, 32'd2);
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd9, 32'd3);
    wait_done("flush_restart", 32'd3, 33, 1);

    // Same with reset instead of flush
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_result", result, 32'd0);
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd9, 32'd3);
    wait_done("rst_restart", 32'd3, 33, 1);

    // Back-to-back: start B in A's done cycle; a start during B's busy is ignored
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd200, 32'd9);
    wait_done("b2b_a", 32'd22, 33, 1);
    launch(DIV_OP_DIVU, 32'd77, 32'd5);
    check("b2b_busy_c1", {31'd0, busy}, 32'd1);
    check("b2b_hold_c1", result, 32'd22);
    launch(DIV_OP_DIVU, 32'd1, 32'd0);
    check("b2b_ignore_busy", {31'd0, busy}, 32'd1);
    check("b2b_hold_c2", result, 32'd22);
    wait_done("b2b_b", 32'd15, 33, 2);

    // Flush together with start in the done cycle: done still shown, start dropped
    @(negedge clk);
    launch(DIV_OP_DIVU, 32'd50, 32'd3);
    wait_done("flush_done", 32'd16, 33, 1);
    flush = 1'b1;
    launch(DIV_OP_DIVU, 32'd5, 32'd0);
    flush = 1'b0;
    check("fdone_done", {31'd0, done}, 32'd0);
    check("fdone_busy", {31'd0, busy}, 32'd0);
    check("fdone_res", result, 32'd16);

    // Flush with start while idle: start dropped
    @(negedge clk);
    flush = 1'b1;
    launch(DIV_OP_DIVU, 32'd5, 32'd0);
    flush = 1'b0;
    check("fidle_done", {31'd0, done}, 32'd0);
    check("fidle_busy", {31'd0, busy}, 32'd0);
    check("fidle_res", result, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
